// File: rtl/dm_lsu.sv
// dm_lsu: multi-cycle load/store unit with an internal word-addressed data memory.
// Accepts one access in IDLE, waits WAIT_CYC cycles, performs it, then pulses mm_done.
`timescale 1ns/1ps

// state  | meaning
// S_IDLE | waiting for mm_req; request fields latched on acceptance
// S_WAIT | counting down wait states; access performed when r_cnt reaches 0
// S_DONE | mm_done/addr_err pulse cycle; mm_req ignored
module dm_lsu #(
  parameter int AW       = 16,
  parameter int DW       = 32,
  parameter int DEPTH    = 256,
  parameter int WAIT_CYC = 2
) (
  input  logic          clk,
  input  logic          rst_f,
  input  logic          mm_req,
  input  logic          mm_we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wr_dat,
  output logic [DW-1:0] rd_dat,
  output logic          mm_busy,
  output logic          mm_done,
  output logic          addr_err
);

  localparam int          MW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  logic [3:0]    r_cnt;
  logic [AW-1:0] r_addr;
  logic          r_we;
  logic [DW-1:0] r_wdat;
  logic [DW-1:0] r_mem [DEPTH];

  logic          w_in_range;
  logic          w_access;
  logic          w_mem_we;
  logic [MW-1:0] w_idx;

  // Full-width compare so out-of-range addresses never alias onto low words.
  assign w_in_range = ({1'b0, r_addr} < LP_DEPTH);
  assign w_idx      = r_addr[MW-1:0];
  assign w_access   = (r_state == S_WAIT) && (r_cnt == 4'd0);
  assign w_mem_we   = w_access && r_we && w_in_range;

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_addr   <= '0;
      r_we     <= 1'b0;
      r_wdat   <= '0;
      rd_dat   <= '0;
      mm_busy  <= 1'b0;
      mm_done  <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          mm_done  <= 1'b0;
          addr_err <= 1'b0;
          if (mm_req) begin
            r_addr  <= addr;
            r_we    <= mm_we;
            r_wdat  <= wr_dat;
            r_cnt   <= 4'(WAIT_CYC);
            mm_busy <= 1'b1;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            mm_busy  <= 1'b0;
            mm_done  <= 1'b1;
            addr_err <= !w_in_range;
            if (!r_we) begin
              rd_dat <= w_in_range ? r_mem[w_idx] : '0;
            end
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          mm_done  <= 1'b0;
          addr_err <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Memory has no reset; a write can only happen from S_WAIT, so reset aborts it.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_idx] <= r_wdat;
    end
  end

endmodule
